fsk_symbol_sequencer: RTL

- Upstream stage of the carrier-bank antenna transmitter.
- Accepts bytes over a valid/ready stream (typically from the UART receiver) and buffers them in a small FIFO.
- Serialises each byte into timed FSK symbols. Each symbol drives the 7-bit carrier bin select and the key/enable bit that gate the selected carrier onto the PMOD output.
- Replaces the fixed switch/slow-carrier keying with framed data transmission.

---
 rtl/fsk_symbol_sequencer_if.sv | 11 +
 rtl/fsk_symbol_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fsk_symbol_sequencer_if.sv
// Byte stream interface feeding the FSK symbol sequencer.
// The master (typically a UART receiver) drives IN_DATA/IN_VALID, and the
// sequencer answers with IN_READY while its input FIFO has room.
interface fsk_symbol_sequencer_if;
  logic [7:0] IN_DATA;
  logic       IN_VALID;
  logic       IN_READY;

  modport master (output IN_DATA, output IN_VALID, input IN_READY);
  modport slave  (input IN_DATA, input IN_VALID, output IN_READY);
endinterface

// File: rtl/fsk_symbol_sequencer.sv
// FSK symbol sequencer: buffers incoming bytes in a small FIFO and sends each
// one as a framed run of timed symbols (START, D0..D7 LSB-first, STOP).
// Each symbol selects MARK_BIN or SPACE_BIN on BIN and holds KEY high while a
// frame is on air. SYMBOL_STROBE marks the first cycle of every symbol.
// Optional build macro FSK_SEQ_PARITY_EN adds an even-parity symbol between
// D7 and STOP, which makes frames 11 symbols long instead of 10.
module fsk_symbol_sequencer #(
  parameter int CLK_FREQ    = 100000000,
  parameter int SYMBOL_RATE = 100,
  parameter int FIFO_DEPTH  = 4,
  parameter int MARK_BIN    = 20,
  parameter int SPACE_BIN   = 10
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      ENABLE,
  fsk_symbol_sequencer_if.slave     stream,
  output logic [6:0]                BIN,
  output logic                      KEY,
  output logic                      BUSY,
  output logic                      SYMBOL_STROBE
);

  localparam int SC = CLK_FREQ / SYMBOL_RATE;
  localparam int CW = (SC > 1) ? $clog2(SC) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(SC - 1);
  localparam logic [NW-1:0] FULL     = NW'(FIFO_DEPTH);
  localparam logic [6:0]    MARK     = 7'(MARK_BIN);
  localparam logic [6:0]    SPACE    = 7'(SPACE_BIN);

  // Reject parameter sets that would produce a fractional or degenerate
  // symbol period, a non-power-of-two FIFO, or indistinguishable bins.
  if (CLK_FREQ % SYMBOL_RATE != 0 || SC < 2) begin : g_bad_rate
    $error("fsk_symbol_sequencer: CLK_FREQ/SYMBOL_RATE must divide exactly and be >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fsk_symbol_sequencer: FIFO_DEPTH must be a power of two >= 2");
  end
  if (MARK_BIN < 0 || MARK_BIN > 127 || SPACE_BIN < 0 || SPACE_BIN > 127
      || MARK_BIN == SPACE_BIN) begin : g_bad_bins
    $error("fsk_symbol_sequencer: bins must be 0..127 and MARK_BIN != SPACE_BIN");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [NW-1:0] count;
  logic [NW-1:0] count_next;
  logic          ready_q;
  logic          push;
  logic          pop;
  logic          empty;

  assign push            = stream.IN_VALID && ready_q;
  assign empty           = (count == '0);
  assign stream.IN_READY = ready_q;

  // Occupancy after this cycle; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + NW'(1);
      2'b01:   count_next = count - NW'(1);
      default: count_next = count;
    endcase
  end

  // FIFO pointers, occupancy and the registered ready flag (low while in reset).
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count   <= count_next;
      ready_q <= (count_next != FULL);
    end
  end

  // Storage array needs no reset; the pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= stream.IN_DATA;
  end

  // ---------------------------------------------------------------------------
  // Frame sequencer
  // ---------------------------------------------------------------------------
  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_next;
  logic [7:0]    data_q;
  logic [7:0]    data_next;
  logic          sym_end;
  logic          can_start;
  logic [6:0]    bin_next;
  logic          key_next;
  logic          strobe_next;

  assign sym_end   = (cnt == CNT_LAST);
  assign can_start = ENABLE && !empty;
  assign BUSY      = (state != IDLE) || !empty;

  // State register plus registered outputs, so BIN/KEY only move on symbol edges.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      data_q        <= '0;
      BIN           <= MARK;
      KEY           <= 1'b0;
      SYMBOL_STROBE <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      bit_idx       <= bit_next;
      data_q        <= data_next;
      BIN           <= bin_next;
      KEY           <= key_next;
      SYMBOL_STROBE <= strobe_next;
    end
  end

  // Next-state logic: the symbol timer free-runs inside a frame, and a new
  // byte is popped either from IDLE or on the last STOP cycle for gapless frames.
  always_comb begin
    state_next = state;
    cnt_next   = sym_end ? '0 : cnt + CW'(1);
    bit_next   = bit_idx;
    data_next  = data_q;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (can_start) begin
          state_next = START;
          pop        = 1'b1;
          data_next  = mem[rd_ptr];
        end
      end
      START: begin
        if (sym_end) begin
          state_next = DATA;
          bit_next   = '0;
        end
      end
      DATA: begin
        if (sym_end) begin
          if (bit_idx == 3'd7) begin
`ifdef FSK_SEQ_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end
      end
`ifdef FSK_SEQ_PARITY_EN
      PARITY: begin
        if (sym_end) state_next = STOP;
      end
`endif
      STOP: begin
        if (sym_end) begin
          if (can_start) begin
            state_next = START;
            pop        = 1'b1;
            data_next  = mem[rd_ptr];
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output values for the coming cycle, derived from where the FSM is heading.
  always_comb begin
    bin_next    = MARK;
    key_next    = (state_next != IDLE);
    strobe_next = (state_next != IDLE) && (cnt_next == '0);
    case (state_next)
      START:   bin_next = SPACE;
      DATA:    bin_next = data_next[bit_next] ? MARK : SPACE;
      PARITY:  bin_next = (^data_next) ? MARK : SPACE;
      default: bin_next = MARK;
    endcase
  end

endmodule
